// File: rtl/mul_sequencer.sv
// Iterative shift-add multiply sequencer for the LEGv8 pipeline.
// Captures the EX-stage operands of a MUL, stalls the front of the pipe while
// it consumes STEP multiplier bits per cycle, then presents the truncated
// product and a writeback enable for one cycle.
module mul_sequencer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             wr_en,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out
);

  localparam int unsigned NSTEPS = WIDTH / STEP;
  localparam int unsigned CW     = $clog2(NSTEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] accReg;
  logic [CW-1:0]    cntReg;
  logic [4:0]       rdReg;
  logic             doneQ;
  logic             wrEnQ;

  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] accNext;
  logic [WIDTH-1:0] aNext;
  logic [WIDTH-1:0] bNext;
  logic [CW-1:0]    cntNext;

  // Next-iteration datapath: one STEP-bit digit of the multiplier per cycle.
  always_comb begin
    partial = '0;
    partial = aReg * WIDTH'(bReg[STEP-1:0]);
    accNext = accReg + partial;
    aNext   = aReg << STEP;
    bNext   = bReg >> STEP;
    cntNext = cntReg - CW'(1);
  end

  // Control FSM with captured operands and registered result/writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      aReg   <= '0;
      bReg   <= '0;
      accReg <= '0;
      cntReg <= '0;
      rdReg  <= '0;
      doneQ  <= 1'b0;
      wrEnQ  <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          doneQ <= 1'b0;
          wrEnQ <= 1'b0;
          if (start && !flush) begin
            aReg   <= op_a;
            bReg   <= op_b;
            rdReg  <= rd_in;
            accReg <= '0;
            cntReg <= CW'(NSTEPS);
            state  <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            accReg <= accNext;
            aReg   <= aNext;
            bReg   <= bNext;
            cntReg <= cntNext;
            // Exit once no multiplier bits remain; the product is final.
            if (cntNext == '0 || bNext == '0) begin
              state  <= DONE;
              result <= accNext;
              rd_out <= rdReg;
              doneQ  <= 1'b1;
              wrEnQ  <= (rdReg != 5'd31);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          doneQ <= 1'b0;
          wrEnQ <= 1'b0;
        end
        default: begin
          state <= IDLE;
          doneQ <= 1'b0;
          wrEnQ <= 1'b0;
        end
      endcase
    end
  end

  // Stall must assert in the accept cycle and drop at once on a flush.
  always_comb begin
    stall = !flush && (((state == IDLE) && start) || (state == RUN));
    busy  = (state != IDLE);
    done  = doneQ && !flush;
    wr_en = wrEnQ && !flush;
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: the driver pushes expected writebacks,
// the monitor pops and checks them whenever done is presented.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        stall, busy, done, wr_en;
  logic [63:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        wr;
    int          doneCyc;
  } exp_t;

  exp_t q[$];

  mul_sequencer #(.WIDTH(64), .STEP(4)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .stall(stall), .busy(busy), .done(done), .wr_en(wr_en),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare each done pulse with the oldest expected writeback.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", result, e.res);
          chk("rd_out", 64'(rd_out), 64'(e.rd));
          chk("wr_en", 64'(wr_en), 64'(e.wr));
          chk("done_cycle", 64'(cyc), 64'(e.doneCyc));
        end
      end else begin
        chk("wr_en_idle", 64'(wr_en), 64'd0);
      end
    end
  end

  // Called at posedge+1; leaves the bench at posedge+1 of the first RUN cycle.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                       input logic [63:0] expRes, input int k, input bit pushIt);
    exp_t e;
    op_a  = a;
    op_b  = b;
    rd_in = rd;
    start = 1'b1;
    if (pushIt) begin
      e.res = expRes;
      e.rd = rd;
      e.wr = (rd != 5'd31);
      e.doneCyc = cyc + k + 1;
      q.push_back(e);
    end
    #1 chk("stall_accept", 64'(stall), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL timeout_busy actual=1 required=0 (cycle %0d)", cyc);
    end
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_rd_out", 64'(rd_out), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // 3*5, then a start presented during DONE must be ignored
    issue(64'd3, 64'd5, 5'd2, 64'd15, 1, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; op_a = 64'd9; op_b = 64'd9;
    #1 chk("stall_in_done", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_ignored", 64'(busy), 64'd0);
    chk("result_hold", result, 64'd15);

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1'b1);
    waitIdle();
    issue(64'd5, 64'd0, 5'd31, 64'd0, 1, 1'b1);
    waitIdle();
    issue(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd1, 64'hFFFF_FFFF_FFFF_FFF1, 1, 1'b1);
    waitIdle();

    // start during RUN is ignored; 0x1234*0x100 needs 3 digits
    issue(64'h1234, 64'h100, 5'd0, 64'h12_3400, 3, 1'b1);
    start = 1'b1; op_a = 64'd1; op_b = 64'd1; rd_in = 5'd5;
    #1 chk("stall_run", 64'(stall), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    waitIdle();

    issue(64'h10, 64'hFFFF, 5'd7, 64'hF_FFF0, 4, 1'b1);
    waitIdle();

    // Worst case: stall high through every RUN cycle, low in DONE
    issue(64'd1, 64'h8000_0000_0000_0000, 5'd4, 64'h8000_0000_0000_0000, 16, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      chk("stall_long", 64'(stall), 64'd1);
      @(posedge clk); #1;
    end
    chk("stall_done", 64'(stall), 64'd0);
    chk("done_long", 64'(done), 64'd1);
    waitIdle();

    // flush and start together in IDLE: flush wins
    start = 1'b1; flush = 1'b1; op_a = 64'd2; op_b = 64'd2;
    #1 chk("stall_flush_idle", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("busy_flush_idle", 64'(busy), 64'd0);

    // Flush at cycle 3 of a long multiply
    issue(64'd1, 64'h8000_0000_0000_0000, 5'd6, 64'd0, 16, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    #1 chk("stall_flush", 64'(stall), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("busy_after_flush", 64'(busy), 64'd0);
    chk("stall_after_flush", 64'(stall), 64'd0);
    chk("result_after_flush", result, 64'h8000_0000_0000_0000);
    chk("rd_after_flush", 64'(rd_out), 64'd4);
    issue(64'd7, 64'd6, 5'd9, 64'd42, 1, 1'b1);
    waitIdle();

    // Reset at cycle 5 of a run, then immediate restart
    issue(64'd1, 64'h8000_0000_0000_0000, 5'd8, 64'd0, 16, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", result, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(64'd3, 64'd5, 5'd2, 64'd15, 1, 1'b1);
    waitIdle();

    @(posedge clk); #1;
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
